// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One bit per cycle for WIDTH cycles, then one cycle to apply result signs.
module mul_div_unit #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mdop,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]    cnt_q;
    logic [WIDTH-1:0]   mag_a_q, mag_b_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH:0]     rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic               is_div_q, neg_res_q, neg_rem_q, div_zero_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Operand magnitudes and one iteration of shift-add / restoring divide.
    always_comb begin
        a_neg     = !mdop[0] && a[WIDTH-1];
        b_neg     = !mdop[0] && b[WIDTH-1];
        mag_a     = a_neg ? -a : a;
        mag_b     = b_neg ? -b : b;
        // Multiplier sits in the low half and is consumed LSB first.
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
        div_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mag_b_q};
    end

    // Sign fix-up of the unsigned result, divide-by-zero override.
    always_comb begin
        prod_fix = neg_res_q ? -prod_q : prod_q;
        quo_fix  = neg_res_q ? -quo_q : quo_q;
        rem_fix  = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        if (is_div_q) begin
            fix_hi = rem_fix;
            fix_lo = div_zero_q ? DIV0_LO : quo_fix;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start && !mdop[2]) state_d = StRun;
            StRun:   if (cnt_q == CntLast) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath, HI/LO and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            prod_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == StFix);
            unique case (state_q)
                StIdle: begin
                    if (start && !mdop[2]) begin
                        cnt_q      <= '0;
                        mag_a_q    <= mag_a;
                        mag_b_q    <= mag_b;
                        prod_q     <= {{WIDTH{1'b0}}, mag_b};
                        rem_q      <= '0;
                        quo_q      <= mag_a;
                        is_div_q   <= mdop[1];
                        neg_res_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        div_zero_q <= (b == '0);
                    end else if (start && mdop[2:1] == 2'b10) begin
                        if (mdop[0]) lo_q <= a;
                        else         hi_q <= a;
                    end
                end
                StRun: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (is_div_q) begin
                        if (!div_diff[WIDTH+1]) begin
                            rem_q <= div_diff[WIDTH:0];
                            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_q <= div_shift;
                            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
                    end
                end
                StFix: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner vectors, MTHI/MTLO,
// ignored requests, reset abort, back-to-back and randomized ops vs a model.
module tb_mul_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset, start, busy, done;
    logic [2:0]    mdop;
    logic [W-1:0]  a, b, hi, lo;

    int            total = 0;
    int            bad = 0;
    logic [W-1:0]  exp_hi = '0;
    logic [W-1:0]  exp_lo = '0;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .mdop  (mdop),
        .start (start),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Architectural result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        logic [63:0]     q, r, res;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        res = '0;
        case (op)
            3'd0: res = sx * sy;
            3'd1: res = ux * uy;
            3'd2, 3'd3: begin
                if (y == 32'd0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else begin
                    if (op == 3'd2) begin
                        q = sx / sy;
                        r = sx % sy;
                    end else begin
                        q = ux / uy;
                        r = ux % uy;
                    end
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called at #1 after an edge; returns at #1 after the edge that raises done.
    task automatic run_op(input logic [2:0] op, input logic [31:0] oa, input logic [31:0] ob,
                          input bit pester);
        logic [63:0] r;
        int          n;
        bit          busy_ok, hold_ok;
        r = model(op, oa, ob);
        start = 1'b1; mdop = op; a = oa; b = ob;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL launch op=%0d: busy=%b done=%b, required busy=1 done=0", op, busy, done);
        end
        n = 0; busy_ok = 1'b1; hold_ok = 1'b1;
        while (done !== 1'b1 && n < 50) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (hi !== exp_hi || lo !== exp_lo) hold_ok = 1'b0;
            if (pester) begin
                start = 1'b1; mdop = 3'($urandom_range(0, 5)); a = $urandom; b = $urandom;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        total++;
        if (n != W + 1) begin
            bad++;
            $display("FAIL latency op=%0d: got %0d cycles, required %0d", op, n, W + 1);
        end
        total++;
        if (!busy_ok || !hold_ok || busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_hold op=%0d: busy_ok=%0d hold_ok=%0d busy_at_done=%b, required 1 1 0",
                     op, busy_ok, hold_ok, busy);
        end
        total++;
        if (hi !== r[63:32] || lo !== r[31:0]) begin
            bad++;
            $display("FAIL result op=%0d a=%h b=%h: hi=%h lo=%h, required hi=%h lo=%h",
                     op, oa, ob, hi, lo, r[63:32], r[31:0]);
        end
        exp_hi = r[63:32];
        exp_lo = r[31:0];
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mdop = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
        end
    endtask

    task automatic test_directed();
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        total++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            bad++;
            $display("FAIL div_neg7_2: hi=%h lo=%h, required ffffffff fffffffd", hi, lo);
        end
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'd3, 32'd5, 32'd0, 1'b0);
        total++;
        if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL divu_by_zero: hi=%h lo=%h, required 00000005 ffffffff", hi, lo);
        end
        run_op(3'd2, 32'hFFFF_FFF9, 32'd0, 1'b0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_mt();
        start = 1'b1; mdop = 3'b100; a = 32'h1234;
        @(posedge clk); #1;
        mdop = 3'b101; a = 32'h5678;
        exp_hi = 32'h1234;
        total++;
        if (hi !== exp_hi || lo !== exp_lo || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL mthi: hi=%h lo=%h busy=%b done=%b, required hi=%h lo=%h 0 0",
                     hi, lo, busy, done, exp_hi, exp_lo);
        end
        @(posedge clk); #1;
        start = 1'b0;
        exp_lo = 32'h5678;
        total++;
        if (hi !== exp_hi || lo !== exp_lo || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b, required hi=%h lo=%h 0 0",
                     hi, lo, busy, done, exp_hi, exp_lo);
        end
    endtask

    task automatic test_ignored_ops();
        for (int k = 6; k <= 7; k++) begin
            start = 1'b1; mdop = 3'(k); a = $urandom; b = $urandom;
            @(posedge clk); #1;
            start = 1'b0;
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
                bad++;
                $display("FAIL ignored_mdop%0d: busy=%b done=%b hi=%h lo=%h, required 0 0 %h %h",
                         k, busy, done, hi, lo, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_busy_ignore_and_back_to_back();
        run_op(3'd0, 32'd12345, 32'hFFFF_FF00, 1'b1);
        run_op(3'd3, 32'hDEAD_BEEF, 32'd77, 1'b1);
        run_op(3'd2, 32'h8765_4321, 32'hFFFF_FFF3, 1'b0);
        run_op(3'd1, 32'hCAFE_F00D, 32'h1357_9BDF, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        start = 1'b1; mdop = 3'd0; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
        end
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        total++;
        if (saw_done) begin
            bad++;
            $display("FAIL reset_abort: activity seen after reset=1, required none=0");
        end
        run_op(3'd0, 32'd6, 32'd7, 1'b0);
        total++;
        if (lo !== 32'd42 || hi !== 32'd0) begin
            bad++;
            $display("FAIL mult_6x7: hi=%h lo=%h, required 00000000 0000002a", hi, lo);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 3)), pick(), pick(), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mt();
        test_ignored_ops();
        test_busy_ignore_and_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
